// File: rtl/johnson_pkg.sv
// Shared Johnson-counter helpers: direction encoding, legality check and phase decode.
package johnson_pkg;

  localparam int JC_MAX_WIDTH = 32;

  typedef enum logic {
    JC_FWD = 1'b0,
    JC_REV = 1'b1
  } jc_dir_e;

  // Legal Johnson codes have at most one boundary between adjacent bits of the low w bits.
  function automatic logic jc_is_legal(logic [31:0] v, int w);
    logic [31:0] mask;
    mask = (32'd1 << (w - 1)) - 32'd1;
    return $countones((v ^ (v >> 1)) & mask) <= 1;
  endfunction

  // v must be zero above bit w-1; ones-filled-from-top codes are phase 0..w,
  // ones-filled-from-bottom codes are phase w+1..2w-1, illegal codes map to 0.
  function automatic int jc_phase(logic [31:0] v, int w);
    int ones;
    ones = $countones(v);
    if (!jc_is_legal(v, w)) return 0;
    if (((v >> (w - 1)) != 32'd0) || (v == 32'd0)) return ones;
    return 2 * w - ones;
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Pure combinational decode of a Johnson state into its phase index and legality flag.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PHW   = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q_i,
  output logic [PHW-1:0]   phase_o,
  output logic             legal_o
);

  always_comb begin
    legal_o = jc_is_legal(32'(q_i), WIDTH);
    phase_o = PHW'(jc_phase(32'(q_i), WIDTH));
  end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter with enable, direction, synchronous load and wrap pulse.
// Define JOHNSON_SELF_CORRECT_EN to force illegal states to zero and pulse err.
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PHW   = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PHW-1:0]   phase,
  output logic             wrap,
  output logic             err
);

  localparam logic [PHW-1:0] LAST_PHASE = PHW'(2 * WIDTH - 1);
  localparam logic [PHW-1:0] PHASE_ONE  = PHW'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] step_fwd;
  logic [WIDTH-1:0] step_rev;
  logic             wrap_q;
  logic             wrap_d;
  logic             err_q;
  logic             err_d;
  logic             legal;
  logic             wrap_hit;
  jc_dir_e          dir_e;

  johnson_phase_decode #(
    .WIDTH(WIDTH),
    .PHW  (PHW)
  ) u_decode (
    .q_i    (q_q),
    .phase_o(phase),
    .legal_o(legal)
  );

  always_comb begin
    q_d      = q_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    dir_e    = jc_dir_e'(dir);
    step_fwd = {~q_q[0], q_q[WIDTH-1:1]};
    step_rev = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    // The step that enters phase 0 comes from the last phase going forward, phase 1 in reverse.
    wrap_hit = legal && ((dir_e == JC_REV) ? (phase == PHASE_ONE) : (phase == LAST_PHASE));
    if (load) begin
`ifdef JOHNSON_SELF_CORRECT_EN
      if (jc_is_legal(32'(load_val), WIDTH)) begin
        q_d = load_val;
      end else begin
        q_d   = '0;
        err_d = 1'b1;
      end
`else
      q_d = load_val;
`endif
    end else if (en) begin
`ifdef JOHNSON_SELF_CORRECT_EN
      if (!legal) begin
        q_d   = '0;
        err_d = 1'b1;
      end else begin
        q_d    = (dir_e == JC_REV) ? step_rev : step_fwd;
        wrap_d = wrap_hit;
      end
`else
      q_d    = (dir_e == JC_REV) ? step_rev : step_fwd;
      wrap_d = wrap_hit;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed self-checking bench for johnson_counter_param at WIDTH=4, 2 and 7.
module tb_johnson_counter_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] phase;
  logic       wrap;
  logic       err;

  logic       w_en;
  logic       w_dir;
  logic       w_load;
  logic [1:0] lv2;
  logic [1:0] q2;
  logic [1:0] ph2;
  logic       wrap2;
  logic       err2;
  logic [6:0] lv7;
  logic [6:0] q7;
  logic [3:0] ph7;
  logic       wrap7;
  logic       err7;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  johnson_counter_param #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .phase(phase), .wrap(wrap), .err(err)
  );

  johnson_counter_param #(.WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(w_en), .dir(w_dir), .load(w_load),
    .load_val(lv2), .q(q2), .phase(ph2), .wrap(wrap2), .err(err2)
  );

  johnson_counter_param #(.WIDTH(7)) dut7 (
    .clk(clk), .reset_n(reset_n), .en(w_en), .dir(w_dir), .load(w_load),
    .load_val(lv7), .q(q7), .phase(ph7), .wrap(wrap7), .err(err7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
    w_en = 1'b0; w_dir = 1'b0; w_load = 1'b0; lv2 = '0; lv7 = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({q, wrap, err} !== 6'b0) $display("FAIL reset_async: got q=%b wrap=%b err=%b expected 0000/0/0", q, wrap, err);
    else passed++;
    tick();
    tick();
    checks++;
    if ({q, phase, wrap, err} !== 9'b0) $display("FAIL reset_hold: got q=%b phase=%0d wrap=%b err=%b expected 0", q, phase, wrap, err);
    else passed++;
    en = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000) $display("FAIL reset_release: got q=%b expected 0000", q);
    else passed++;
  endtask

  task automatic test_forward();
    logic [3:0] fq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (q !== fq[i] || phase !== 3'((i + 1) % 8) || wrap !== (i == 7))
        $display("FAIL fwd[%0d]: got q=%b phase=%0d wrap=%b expected q=%b phase=%0d wrap=%b",
                 i, q, phase, wrap, fq[i], (i + 1) % 8, (i == 7));
      else passed++;
    end
  endtask

  task automatic test_reverse_dirchange();
    logic [3:0] rq [5] = '{4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    logic       rw [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    en = 1'b1; dir = 1'b0;
    repeat (3) tick();
    checks++;
    if (q !== 4'b1110 || phase !== 3'd3) $display("FAIL rev_setup: got q=%b phase=%0d expected 1110/3", q, phase);
    else passed++;
    dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) dir = 1'b0;
      tick();
      checks++;
      if (q !== rq[i] || wrap !== rw[i])
        $display("FAIL rev[%0d]: got q=%b wrap=%b expected q=%b wrap=%b", i, q, wrap, rq[i], rw[i]);
      else passed++;
    end
  endtask

  task automatic test_load();
    en = 1'b1; dir = 1'b1; load = 1'b1; load_val = 4'b0111;
    tick();
    checks++;
    if (q !== 4'b0111 || phase !== 3'd5 || wrap !== 1'b0)
      $display("FAIL load_prio: got q=%b phase=%0d wrap=%b expected 0111/5/0", q, phase, wrap);
    else passed++;
    load = 1'b0; dir = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0011 || phase !== 3'd6) $display("FAIL load_then_en: got q=%b phase=%0d expected 0011/6", q, phase);
    else passed++;
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0001 || wrap !== 1'b0) $display("FAIL hold: got q=%b wrap=%b expected 0001/0", q, wrap);
    else passed++;
    en = 1'b1; load = 1'b1; load_val = 4'b0000;
    tick();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b0) $display("FAIL load_no_wrap: got q=%b wrap=%b expected 0000/0", q, wrap);
    else passed++;
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 4'b1111;
    tick();
    load = 1'b0; en = 1'b1;
    checks++;
    if (q !== 4'b1111) $display("FAIL areset_setup: got q=%b expected 1111", q);
    else passed++;
    reset_n = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b0 || err !== 1'b0)
      $display("FAIL areset_mid: got q=%b wrap=%b err=%b expected 0000/0/0", q, wrap, err);
    else passed++;
    #5 reset_n = 1'b1;
    en = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0000) $display("FAIL areset_release: got q=%b expected 0000", q);
    else passed++;
  endtask

  task automatic test_self_correct();
    en = 1'b0; load = 1'b1; load_val = 4'b0101;
    tick();
    load = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
    checks++;
    if (q !== 4'b0000 || err !== 1'b1) $display("FAIL sc_load: got q=%b err=%b expected 0000/1", q, err);
    else passed++;
    tick();
    checks++;
    if (q !== 4'b0000 || err !== 1'b0) $display("FAIL sc_pulse: got q=%b err=%b expected 0000/0", q, err);
    else passed++;
    en = 1'b1;
    tick();
    checks++;
    if (q !== 4'b1000 || err !== 1'b0) $display("FAIL sc_step: got q=%b err=%b expected 1000/0", q, err);
    else passed++;
`else
    checks++;
    if (q !== 4'b0101 || phase !== 3'd0 || err !== 1'b0)
      $display("FAIL sc_load: got q=%b phase=%0d err=%b expected 0101/0/0", q, phase, err);
    else passed++;
    tick();
    checks++;
    if (q !== 4'b0101 || err !== 1'b0) $display("FAIL sc_hold: got q=%b err=%b expected 0101/0", q, err);
    else passed++;
    en = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0010 || err !== 1'b0 || wrap !== 1'b0)
      $display("FAIL sc_step: got q=%b err=%b wrap=%b expected 0010/0/0", q, err, wrap);
    else passed++;
`endif
    en = 1'b0;
  endtask

  task automatic test_width_sweep();
    logic [1:0] t2 [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [6:0] exp7;
    int p7;
    int p2;
    int wraps2 = 0;
    int wraps7 = 0;
    w_en = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      p7 = e % 14;
      p2 = e % 4;
      exp7 = (p7 <= 7) ? 7'(((1 << p7) - 1) << (7 - p7)) : 7'((1 << (14 - p7)) - 1);
      if (wrap7) wraps7++;
      if (wrap2) wraps2++;
      checks++;
      if (q7 !== exp7 || ph7 !== 4'(p7) || wrap7 !== (p7 == 0))
        $display("FAIL w7[%0d]: got q=%b phase=%0d wrap=%b expected q=%b phase=%0d wrap=%b",
                 e, q7, ph7, wrap7, exp7, p7, (p7 == 0));
      else passed++;
      checks++;
      if (q2 !== t2[p2] || ph2 !== 2'(p2) || wrap2 !== (p2 == 0))
        $display("FAIL w2[%0d]: got q=%b phase=%0d wrap=%b expected q=%b phase=%0d wrap=%b",
                 e, q2, ph2, wrap2, t2[p2], p2, (p2 == 0));
      else passed++;
    end
    checks++;
    if (wraps7 !== 1 || wraps2 !== 3)
      $display("FAIL wrap_count: got w7=%0d w2=%0d expected 1/3", wraps7, wraps2);
    else passed++;
    w_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_dirchange();
    test_load();
    test_async_reset();
    test_self_correct();
    test_width_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
